// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage: byte-serial fetch of 32-bit words into IF/ID
module if_stage #(
  parameter int               ADDR_W   = 32,
  parameter int               INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_ready_i,
  input  logic              branch_en_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_rvalid_i,
  input  logic [7:0]        mem_rdata_i,
  output logic              if_valid_o,
  output logic [ADDR_W-1:0] if_pc_o,
  output logic [INST_W-1:0] if_inst_o
);

  // Instructions are always four little-endian bytes; bytes 0..2 are staged
  // here and byte 3 is merged straight into the delivered word.
  typedef enum logic [2:0] {
    S_IDLE,
    S_F0,
    S_F1,
    S_F2,
    S_F3,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_pc;
  logic [INST_W-9:0]   r_buf;
  logic                r_mem_req;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic                r_if_valid;
  logic [ADDR_W-1:0]   r_if_pc;
  logic [INST_W-1:0]   r_if_inst;

  logic [1:0]          w_byte_idx;
  logic [ADDR_W-1:0]   w_addr_next;
  logic [ADDR_W-1:0]   w_pc_plus4;

  // Byte position of the current fetch state and the address of the byte after it
  always_comb begin
    w_byte_idx = 2'd0;
    case (r_state)
      S_F1:    w_byte_idx = 2'd1;
      S_F2:    w_byte_idx = 2'd2;
      S_F3:    w_byte_idx = 2'd3;
      default: w_byte_idx = 2'd0;
    endcase
    w_addr_next = r_pc + {{(ADDR_W-2){1'b0}}, w_byte_idx} + ADDR_W'(1);
    w_pc_plus4  = r_pc + ADDR_W'(4);
  end

  // Fetch FSM; memory request/address and the IF-side outputs are registered
  // so they change only on the clock edge that moves the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_buf      <= '0;
      r_mem_req  <= 1'b0;
      r_mem_addr <= RESET_PC;
      r_if_valid <= 1'b0;
      r_if_pc    <= '0;
      r_if_inst  <= '0;
    end else if (r_state == S_IDLE) begin
      // Branch requests are not honoured until the first fetch has started.
      r_state    <= S_F0;
      r_mem_req  <= 1'b1;
      r_mem_addr <= r_pc;
    end else if (branch_en_i) begin
      // Redirect wins over everything: drop any byte arriving now and any
      // word waiting in DONE, and restart at the target.
      r_state    <= S_F0;
      r_pc       <= branch_target_i;
      r_buf      <= '0;
      r_mem_req  <= 1'b1;
      r_mem_addr <= branch_target_i;
      r_if_valid <= 1'b0;
    end else begin
      case (r_state)
        S_F0: begin
          if (mem_rvalid_i) begin
            r_buf[7:0] <= mem_rdata_i;
            r_state    <= S_F1;
            r_mem_addr <= w_addr_next;
          end
        end
        S_F1: begin
          if (mem_rvalid_i) begin
            r_buf[15:8] <= mem_rdata_i;
            r_state     <= S_F2;
            r_mem_addr  <= w_addr_next;
          end
        end
        S_F2: begin
          if (mem_rvalid_i) begin
            r_buf[23:16] <= mem_rdata_i;
            r_state      <= S_F3;
            r_mem_addr   <= w_addr_next;
          end
        end
        S_F3: begin
          if (mem_rvalid_i) begin
            r_state    <= S_DONE;
            r_mem_req  <= 1'b0;
            r_if_valid <= 1'b1;
            r_if_pc    <= r_pc;
            r_if_inst  <= {mem_rdata_i, r_buf};
          end
        end
        S_DONE: begin
          // Word stays presented until the IF/ID register takes it.
          if (id_ready_i) begin
            r_state    <= S_F0;
            r_pc       <= w_pc_plus4;
            r_mem_req  <= 1'b1;
            r_mem_addr <= w_pc_plus4;
            r_if_valid <= 1'b0;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_mem_req  <= 1'b0;
          r_if_valid <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req_o  = r_mem_req;
  assign mem_addr_o = r_mem_addr;
  assign if_valid_o = r_if_valid;
  assign if_pc_o    = r_if_pc;
  assign if_inst_o  = r_if_inst;

endmodule
